snn_window_classifier: RTL and testbench

Parametrised single-layer spiking classifier with a timestep-window controller. It holds a loadable NUM_OUT×NUM_IN weight array and one leaky integrate-and-fire neuron per output, with per-neuron saturating spike counters. Over a run it consumes a programmable number of input spike vectors through a valid/ready handshake, then scans the counters sequentially and reports the winning class with a one-cycle done pulse. It generalises the fixed 8-in/10-out inference top: arbitrary channel counts, real per-synapse weights, leak, a bounded inference window, backpressure, and tie reporting.

---
 rtl/snn_window_classifier.sv | 273 +++++++++++++++++++++++++++
 tb/tb_snn_window_classifier.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_window_classifier.sv
// snn_window_classifier
// Single-layer spiking classifier: a loadable weight array feeding one leaky
// integrate-and-fire neuron per class, each with a saturating spike counter.
// A run accepts a programmable number of input spike vectors, then scans the
// counters one per cycle to report the winning class, its count, and a tie flag.

module snn_window_classifier #(
  parameter int NUM_IN    = 8,
  parameter int NUM_OUT   = 10,
  parameter int WEIGHT_W  = 4,
  parameter int POT_W     = 8,
  parameter int COUNT_W   = 8,
  parameter int WINDOW_W  = 8,
  parameter int THRESHOLD = 16,
  parameter int LEAK      = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic [WINDOW_W-1:0]                window_i,
  input  logic [NUM_IN-1:0]                  spike_i,
  input  logic                               spike_valid_i,
  output logic                               spike_ready_o,
  input  logic                               wr_en_i,
  input  logic [$clog2(NUM_OUT*NUM_IN)-1:0]  wr_addr_i,
  input  logic [WEIGHT_W-1:0]                wr_data_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [$clog2(NUM_OUT)-1:0]         class_o,
  output logic [COUNT_W-1:0]                 class_count_o,
  output logic                               tie_o,
  output logic [NUM_OUT-1:0]                 out_spike_o
);

  localparam int NUM_W   = NUM_OUT * NUM_IN;
  localparam int ADDR_W  = $clog2(NUM_W);
  localparam int CLASS_W = $clog2(NUM_OUT);
  // Synaptic current is wide enough for every input firing at full weight.
  localparam int SUM_W   = WEIGHT_W + $clog2(NUM_IN + 1);
  // One spare bit above the wider operand so leak+current never wraps.
  localparam int EXT_W   = ((POT_W > SUM_W) ? POT_W : SUM_W) + 1;

  localparam logic [EXT_W-1:0]    POT_MAX  = EXT_W'({POT_W{1'b1}});
  localparam logic [EXT_W-1:0]    THRESH_V = EXT_W'(THRESHOLD);
  localparam logic [POT_W-1:0]    LEAK_V   = POT_W'(LEAK);
  localparam logic [CLASS_W-1:0]  LAST_IDX = CLASS_W'(NUM_OUT - 1);
  localparam logic [ADDR_W:0]     NUM_W_V  = (ADDR_W + 1)'(NUM_W);
  localparam logic [WINDOW_W-1:0] ONE_STEP = WINDOW_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SCAN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [WEIGHT_W-1:0] w_q   [NUM_W];
  logic [WEIGHT_W-1:0] w_d   [NUM_W];
  logic [POT_W-1:0]    pot_q [NUM_OUT];
  logic [POT_W-1:0]    pot_d [NUM_OUT];
  logic [COUNT_W-1:0]  cnt_q [NUM_OUT];
  logic [COUNT_W-1:0]  cnt_d [NUM_OUT];

  logic [NUM_OUT-1:0]  out_spike_q, out_spike_d;
  logic [WINDOW_W-1:0] steps_q, steps_d;
  logic [CLASS_W-1:0]  idx_q, idx_d;
  logic [COUNT_W-1:0]  best_q, best_d;
  logic [CLASS_W-1:0]  best_class_q, best_class_d;
  logic                best_tie_q, best_tie_d;
  logic [CLASS_W-1:0]  class_q, class_d;
  logic [COUNT_W-1:0]  class_count_q, class_count_d;
  logic                tie_q, tie_d;

  // Per-neuron candidate state for the step currently on spike_i.
  logic [POT_W-1:0]    pot_step [NUM_OUT];
  logic [NUM_OUT-1:0]  fire;

  logic accept;
  logic addr_ok;

  assign accept  = (state_q == S_RUN) && spike_valid_i;
  assign addr_ok = {1'b0, wr_addr_i} < NUM_W_V;

  // State register: the only flop of the control FSM.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a zero-length window skips RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (window_i != '0) ? S_RUN : S_SCAN;
        end
      end
      S_RUN: begin
        if (accept && (steps_q == ONE_STEP)) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs decoded directly from the current state.
  always_comb begin
    busy_o        = (state_q != S_IDLE);
    spike_ready_o = (state_q == S_RUN);
    done_o        = (state_q == S_DONE);
  end

  // Leaky integrate-and-fire update for every neuron against the current input vector.
  always_comb begin
    logic [SUM_W-1:0] acc;
    logic [POT_W-1:0] leaked;
    logic [EXT_W-1:0] sum_ext;
    acc     = '0;
    leaked  = '0;
    sum_ext = '0;
    fire    = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      acc = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (spike_i[i]) begin
          acc = acc + SUM_W'(w_q[j*NUM_IN + i]);
        end
      end
      leaked  = (pot_q[j] > LEAK_V) ? (pot_q[j] - LEAK_V) : '0;
      sum_ext = EXT_W'(leaked) + EXT_W'(acc);
      if (sum_ext > POT_MAX) begin
        sum_ext = POT_MAX;
      end
      if (sum_ext >= THRESH_V) begin
        fire[j]     = 1'b1;
        pot_step[j] = '0;
      end else begin
        pot_step[j] = POT_W'(sum_ext);
      end
    end
  end

  // Datapath next state: weight writes, run clearing, step integration and the sequential scan.
  always_comb begin
    for (int k = 0; k < NUM_W; k++) begin
      w_d[k] = w_q[k];
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      pot_d[j] = pot_q[j];
      cnt_d[j] = cnt_q[j];
    end
    out_spike_d   = out_spike_q;
    steps_d       = steps_q;
    idx_d         = '0;
    best_d        = best_q;
    best_class_d  = best_class_q;
    best_tie_d    = best_tie_q;
    class_d       = class_q;
    class_count_d = class_count_q;
    tie_d         = tie_q;

    case (state_q)
      S_IDLE: begin
        if (wr_en_i && addr_ok) begin
          w_d[wr_addr_i] = wr_data_i;
        end
        if (start_i) begin
          for (int j = 0; j < NUM_OUT; j++) begin
            pot_d[j] = '0;
            cnt_d[j] = '0;
          end
          out_spike_d = '0;
          steps_d     = window_i;
        end
      end
      S_RUN: begin
        if (accept) begin
          for (int j = 0; j < NUM_OUT; j++) begin
            pot_d[j] = pot_step[j];
            if (fire[j] && (cnt_q[j] != {COUNT_W{1'b1}})) begin
              cnt_d[j] = cnt_q[j] + COUNT_W'(1);
            end
          end
          out_spike_d = fire;
          steps_d     = steps_q - ONE_STEP;
        end
      end
      S_SCAN: begin
        idx_d = idx_q + CLASS_W'(1);
        if (idx_q == '0) begin
          best_d       = cnt_q[0];
          best_class_d = '0;
          best_tie_d   = 1'b0;
        end else if (cnt_q[idx_q] > best_q) begin
          best_d       = cnt_q[idx_q];
          best_class_d = idx_q;
          best_tie_d   = 1'b0;
        end else if (cnt_q[idx_q] == best_q) begin
          best_tie_d   = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          class_d       = best_class_d;
          class_count_d = best_d;
          tie_d         = best_tie_d;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers with synchronous clear of weights, neurons and results.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_W; k++) begin
        w_q[k] <= '0;
      end
      for (int j = 0; j < NUM_OUT; j++) begin
        pot_q[j] <= '0;
        cnt_q[j] <= '0;
      end
      out_spike_q   <= '0;
      steps_q       <= '0;
      idx_q         <= '0;
      best_q        <= '0;
      best_class_q  <= '0;
      best_tie_q    <= 1'b0;
      class_q       <= '0;
      class_count_q <= '0;
      tie_q         <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_W; k++) begin
        w_q[k] <= w_d[k];
      end
      for (int j = 0; j < NUM_OUT; j++) begin
        pot_q[j] <= pot_d[j];
        cnt_q[j] <= cnt_d[j];
      end
      out_spike_q   <= out_spike_d;
      steps_q       <= steps_d;
      idx_q         <= idx_d;
      best_q        <= best_d;
      best_class_q  <= best_class_d;
      best_tie_q    <= best_tie_d;
      class_q       <= class_d;
      class_count_q <= class_count_d;
      tie_q         <= tie_d;
    end
  end

  assign class_o       = class_q;
  assign class_count_o = class_count_q;
  assign tie_o         = tie_q;
  assign out_spike_o   = out_spike_q;

endmodule

// File: tb/tb_snn_window_classifier.sv
// tb_snn_window_classifier
// Directed bench: two instances share every input, one with default widths and
// one with a 4-bit spike counter so counter saturation is visible.

module tb_snn_window_classifier;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [7:0] window_i;
  logic [7:0] spike_i;
  logic       spike_valid_i;
  logic       wr_en_i;
  logic [6:0] wr_addr_i;
  logic [3:0] wr_data_i;

  logic       ready_a, busy_a, done_a, tie_a;
  logic [3:0] class_a;
  logic [7:0] count_a;
  logic [9:0] out_spike_a;

  logic       ready_b, busy_b, done_b, tie_b;
  logic [3:0] class_b;
  logic [3:0] count_b;
  logic [9:0] out_spike_b;

  int compare_count  = 0;
  int mismatch_count = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  snn_window_classifier dut_a (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .window_i      (window_i),
    .spike_i       (spike_i),
    .spike_valid_i (spike_valid_i),
    .spike_ready_o (ready_a),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .busy_o        (busy_a),
    .done_o        (done_a),
    .class_o       (class_a),
    .class_count_o (count_a),
    .tie_o         (tie_a),
    .out_spike_o   (out_spike_a)
  );

  snn_window_classifier #(.COUNT_W(4)) dut_b (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .window_i      (window_i),
    .spike_i       (spike_i),
    .spike_valid_i (spike_valid_i),
    .spike_ready_o (ready_b),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .busy_o        (busy_b),
    .done_o        (done_b),
    .class_o       (class_b),
    .class_count_o (count_b),
    .tie_o         (tie_b),
    .out_spike_o   (out_spike_b)
  );

  // Advance to just after the next rising edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Single weight write while the design is idle.
  task automatic writeWeight(input int addr, input int data);
    wr_en_i   = 1'b1;
    wr_addr_i = addr[6:0];
    wr_data_i = data[3:0];
    tick();
    wr_en_i   = 1'b0;
  endtask

  // One full run: start, feed window steps (with optional idle gaps and illegal
  // start/write strobes), then wait a bounded time for done and one cycle more.
  task automatic applyStimulus(input int window, input logic [7:0] pattern, input int gap,
                               input bit inject, output int latency, output logic [9:0] last_spikes,
                               output bit hold_ok, output bit busy_after, output bit done_after);
    hold_ok  = 1'b1;
    start_i  = 1'b1;
    window_i = window[7:0];
    tick();
    start_i  = 1'b0;
    if (busy_a !== 1'b1) hold_ok = 1'b0;
    for (int s = 0; s < window; s++) begin
      for (int g = 0; g < gap; g++) begin
        spike_valid_i = 1'b0;
        tick();
        if (busy_a !== 1'b1 || ready_a !== 1'b1) hold_ok = 1'b0;
      end
      spike_valid_i = 1'b1;
      spike_i       = pattern;
      if (inject) begin
        start_i   = 1'b1;
        window_i  = 8'd1;
        wr_en_i   = 1'b1;
        wr_addr_i = 7'd0;
        wr_data_i = 4'd15;
      end
      tick();
      start_i       = 1'b0;
      wr_en_i       = 1'b0;
      spike_valid_i = 1'b0;
      if (busy_a !== 1'b1) hold_ok = 1'b0;
    end
    last_spikes = out_spike_a;
    latency = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done_a === 1'b1) begin
        latency = c;
        break;
      end
    end
    tick();
    busy_after = busy_a;
    done_after = done_a;
  endtask

  // Directed scenario sequence.
  initial begin
    int         lat;
    logic [9:0] spk;
    bit         hold, busy_after, done_after;

    rst_ni = 1'b0;
    start_i = 1'b0; window_i = '0; spike_i = '0; spike_valid_i = 1'b0;
    wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;

    // Reset held for two cycles under random inputs.
    for (int r = 0; r < 2; r++) begin
      start_i       = 1'($urandom_range(0, 1));
      window_i      = 8'($urandom);
      spike_i       = 8'($urandom);
      spike_valid_i = 1'($urandom_range(0, 1));
      wr_en_i       = 1'($urandom_range(0, 1));
      wr_addr_i     = 7'($urandom);
      wr_data_i     = 4'($urandom);
      tick();
    end
    checkOutput("rst_ready", ready_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_done", done_a, 0);
    checkOutput("rst_class", class_a, 0);
    checkOutput("rst_count", count_a, 0);
    checkOutput("rst_tie", tie_a, 0);
    checkOutput("rst_out_spike", out_spike_a, 0);
    start_i = 1'b0; window_i = '0; spike_i = '0; spike_valid_i = 1'b0;
    wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    rst_ni = 1'b1;
    tick();

    $display("[TB] all-zero weights after reset");
    applyStimulus(3, 8'hFF, 0, 1'b0, lat, spk, hold, busy_after, done_after);
    checkOutput("zero_latency", lat, 10);
    checkOutput("zero_class", class_a, 0);
    checkOutput("zero_count", count_a, 0);
    checkOutput("zero_tie", tie_a, 1);

    $display("[TB] zero-length window");
    applyStimulus(0, 8'h00, 0, 1'b0, lat, spk, hold, busy_after, done_after);
    checkOutput("w0_latency", lat, 10);
    checkOutput("w0_class", class_a, 0);
    checkOutput("w0_count", count_a, 0);
    checkOutput("w0_tie", tie_a, 1);

    $display("[TB] basic single-synapse run");
    writeWeight(3*8 + 0, 15);
    applyStimulus(4, 8'h01, 0, 1'b0, lat, spk, hold, busy_after, done_after);
    checkOutput("basic_latency", lat, 10);
    checkOutput("basic_last_spikes", spk, 10'h008);
    checkOutput("basic_class", class_a, 3);
    checkOutput("basic_count", count_a, 2);
    checkOutput("basic_tie", tie_a, 0);
    checkOutput("basic_busy_fall", busy_after, 0);
    checkOutput("basic_done_pulse", done_after, 0);
    checkOutput("basic_busy_held", hold, 1);

    $display("[TB] tie between neurons 2 and 7");
    writeWeight(3*8 + 0, 0);
    writeWeight(2*8 + 0, 15);
    writeWeight(7*8 + 0, 15);
    applyStimulus(4, 8'h01, 0, 1'b0, lat, spk, hold, busy_after, done_after);
    checkOutput("tie_class", class_a, 2);
    checkOutput("tie_count", count_a, 2);
    checkOutput("tie_tie", tie_a, 1);

    $display("[TB] backpressure with gaps");
    writeWeight(2*8 + 0, 0);
    writeWeight(7*8 + 0, 0);
    writeWeight(3*8 + 0, 15);
    applyStimulus(4, 8'h01, 2, 1'b0, lat, spk, hold, busy_after, done_after);
    checkOutput("bp_latency", lat, 10);
    checkOutput("bp_last_spikes", spk, 10'h008);
    checkOutput("bp_class", class_a, 3);
    checkOutput("bp_count", count_a, 2);
    checkOutput("bp_tie", tie_a, 0);
    checkOutput("bp_busy_held", hold, 1);

    $display("[TB] counter saturation");
    for (int i = 0; i < 8; i++) begin
      writeWeight(i, 15);
    end
    applyStimulus(20, 8'hFF, 0, 1'b0, lat, spk, hold, busy_after, done_after);
    checkOutput("sat_wide_class", class_a, 0);
    checkOutput("sat_wide_count", count_a, 20);
    checkOutput("sat_wide_tie", tie_a, 0);
    checkOutput("sat_narrow_class", class_b, 0);
    checkOutput("sat_narrow_count", count_b, 15);
    checkOutput("sat_narrow_tie", tie_b, 0);

    $display("[TB] strobes ignored mid-run");
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    checkOutput("rst2_class", class_a, 0);
    checkOutput("rst2_count", count_a, 0);
    writeWeight(3*8 + 0, 15);
    applyStimulus(4, 8'h01, 0, 1'b1, lat, spk, hold, busy_after, done_after);
    checkOutput("guard_latency", lat, 10);
    checkOutput("guard_class", class_a, 3);
    checkOutput("guard_count", count_a, 2);
    checkOutput("guard_tie", tie_a, 0);

    $display("[TB] reset in the middle of a run");
    start_i  = 1'b1;
    window_i = 8'd4;
    tick();
    start_i = 1'b0;
    spike_i = 8'h01;
    spike_valid_i = 1'b1;
    tick();
    tick();
    spike_valid_i = 1'b0;
    checkOutput("midrun_out_spike", out_spike_a, 10'h008);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    checkOutput("midrun_busy", busy_a, 0);
    checkOutput("midrun_ready", ready_a, 0);
    checkOutput("midrun_out_spike_clr", out_spike_a, 0);
    checkOutput("midrun_done", done_a, 0);
    checkOutput("midrun_class", class_a, 0);
    applyStimulus(3, 8'h01, 0, 1'b0, lat, spk, hold, busy_after, done_after);
    checkOutput("post_rst_class", class_a, 0);
    checkOutput("post_rst_count", count_a, 0);
    checkOutput("post_rst_tie", tie_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
